// File: rtl/multichannel_ss_adc.sv
// -----------------------------------------------------------------------------
// multichannel_ss_adc
//
// Back end for a multi-channel single-slope ADC. One analog ramp and one
// digital count are shared by CHANNELS comparators. A start request discharges
// the ramp for one cycle, then a single count sweep runs. Each channel latches
// the count at the first rising edge of its synchronized comparator output.
// All channel results are published together with a one-cycle valid strobe.
//
// Ports
//   clk_i          : single clock, all logic on its rising edge
//   rst_ni         : synchronous active-low reset
//   start_i        : conversion request, honoured only while idle
//   comp_out_i     : asynchronous comparator outputs, bit i is channel i
//   ramp_reset_o   : high holds the analog ramp discharged
//   busy_o         : high from the ramp-reset cycle through the done cycle
//   valid_o        : one-cycle strobe, results have just been updated
//   hit_o          : bit i set when channel i captured a crossing
//   digital_val_o  : channel i result in bits [i*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module multichannel_ss_adc #(
  parameter int WIDTH       = 8,
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [CHANNELS-1:0]       comp_out_i,
  output logic                      ramp_reset_o,
  output logic                      busy_o,
  output logic                      valid_o,
  output logic [CHANNELS-1:0]       hit_o,
  output logic [CHANNELS*WIDTH-1:0] digital_val_o
);

  localparam logic [WIDTH-1:0] FULL_SCALE = '1;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_RST,
    CONVERT,
    DONE
  } state_e;

  state_e                      state_q;
  logic [WIDTH-1:0]            count_q;
  logic                        ramp_reset_q;
  logic                        busy_q;
  logic                        valid_q;
  logic [CHANNELS-1:0]         hit_q;
  logic [CHANNELS*WIDTH-1:0]   digital_val_q;

  // Per-channel working state for the conversion in progress.
  logic [CHANNELS-1:0]         captured_q;
  logic [CHANNELS-1:0]         captured_d;
  logic [CHANNELS-1:0]         hist_q;
  logic [CHANNELS-1:0]         new_cap;
  logic [WIDTH-1:0]            cap_val_q [CHANNELS];
  logic [WIDTH-1:0]            cap_val_d [CHANNELS];
  logic [CHANNELS*WIDTH-1:0]   result_d;
  logic                        sweep_end;

  // Synchronizer chain; stage 0 is the first flop to see comp_out_i.
  logic [CHANNELS-1:0]         sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]         sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Comparator outputs are asynchronous to clk_i, so each bit passes through
  // SYNC_STAGES flops before any decision is made on it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= comp_out_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Capture decisions for the current CONVERT cycle. A capture happens only on
  // the first rising edge of a channel; the edge history is loaded on ramp
  // reset, so a comparator already high at that point never produces an edge.
  // The sweep ends on full-scale count or once every channel has captured,
  // counting captures made in this same cycle.
  always_comb begin
    new_cap    = '0;
    captured_d = captured_q;
    cap_val_d  = cap_val_q;
    result_d   = '0;
    sweep_end  = 1'b0;
    if (state_q == CONVERT) begin
      new_cap = sync_out & ~hist_q & ~captured_q;
    end
    captured_d = captured_q | new_cap;
    for (int i = 0; i < CHANNELS; i++) begin
      if (new_cap[i]) begin
        cap_val_d[i] = count_q;
      end
      result_d[i*WIDTH +: WIDTH] = captured_d[i] ? cap_val_d[i] : FULL_SCALE;
    end
    sweep_end = (count_q == FULL_SCALE) || (&captured_d);
  end

  // Conversion state machine. Outputs are registered and set on the edge that
  // enters each state, so they line up with the state they describe. Results
  // are loaded on the edge into DONE so they are already visible while valid
  // is high, and they then hold until the next DONE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      count_q       <= '0;
      ramp_reset_q  <= 1'b1;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      hit_q         <= '0;
      digital_val_q <= '0;
      captured_q    <= '0;
      hist_q        <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cap_val_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ramp_reset_q <= 1'b1;
          if (start_i) begin
            state_q <= RAMP_RST;
            busy_q  <= 1'b1;
          end
        end

        RAMP_RST: begin
          count_q      <= '0;
          captured_q   <= '0;
          hist_q       <= sync_out;
          for (int i = 0; i < CHANNELS; i++) begin
            cap_val_q[i] <= '0;
          end
          ramp_reset_q <= 1'b0;
          state_q      <= CONVERT;
        end

        CONVERT: begin
          hist_q     <= sync_out;
          captured_q <= captured_d;
          cap_val_q  <= cap_val_d;
          if (sweep_end) begin
            state_q       <= DONE;
            ramp_reset_q  <= 1'b1;
            valid_q       <= 1'b1;
            hit_q         <= captured_d;
            digital_val_q <= result_d;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          ramp_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign ramp_reset_o  = ramp_reset_q;
  assign busy_o        = busy_q;
  assign valid_o       = valid_q;
  assign hit_o         = hit_q;
  assign digital_val_o = digital_val_q;

endmodule
